// File: rtl/sc_stream_counter_if.sv
// Handshake/data bundle between a stochastic-stream producer and the
// sc_stream_counter. The bipolar result lane exists only when the design is
// built with SC_BIPOLAR_EN defined.
//
// Valid/ready semantics: a sample is consumed on every rising edge where
// bit_valid=1 while the counter is running; a result transfers on the rising
// edge where out_valid=1 and out_ready=1. Once raised, out_valid and result
// stay stable until that transfer edge.
interface sc_stream_counter_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             bit_in;
  logic             bit_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             out_valid;
  logic             busy;
`ifdef SC_BIPOLAR_EN
  logic signed [WIDTH:0] result_bp;

  modport master (
    output start, bit_in, bit_valid, out_ready,
    input  result, out_valid, busy, result_bp
  );

  modport slave (
    input  start, bit_in, bit_valid, out_ready,
    output result, out_valid, busy, result_bp
  );
`else
  modport master (
    output start, bit_in, bit_valid, out_ready,
    input  result, out_valid, busy
  );

  modport slave (
    input  start, bit_in, bit_valid, out_ready,
    output result, out_valid, busy
  );
`endif
endinterface

// File: rtl/sc_stream_counter.sv
// Stochastic-to-binary converter: counts ones in a 1-bit stochastic stream
// over a window of WINDOW valid samples and presents the count with a
// valid/ready handshake. Optional macro SC_BIPOLAR_EN adds a signed bipolar
// result (2*ones - WINDOW) registered alongside the unipolar count.
// WINDOW must lie in 1..2^WIDTH-1 so the counters never overflow.
module sc_stream_counter #(
  parameter int WIDTH  = 8,
  parameter int WINDOW = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  sc_stream_counter_if.slave   bus,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] WINDOW_W = WINDOW[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ones_q, ones_d;
  logic [WIDTH-1:0] samp_q, samp_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] ones_inc;
  logic [WIDTH-1:0] samp_inc;
`ifdef SC_BIPOLAR_EN
  logic signed [WIDTH:0] bp_q, bp_d;
`endif

  // Counts including the sample offered this cycle; used only when it is valid.
  assign ones_inc = ones_q + {{(WIDTH-1){1'b0}}, bus.bit_in};
  assign samp_inc = samp_q + ONE_W;

  // Next-state and datapath updates; everything holds unless a case changes it.
  always_comb begin
    state_d  = state_q;
    ones_d   = ones_q;
    samp_d   = samp_q;
    result_d = result_q;
    valid_d  = valid_q;
`ifdef SC_BIPOLAR_EN
    bp_d     = bp_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          ones_d  = '0;
          samp_d  = '0;
        end
      end
      ST_RUN: begin
        // start is deliberately not looked at while a window is open.
        if (bus.bit_valid) begin
          ones_d = ones_inc;
          samp_d = samp_inc;
          if (samp_inc == WINDOW_W) begin
            result_d = ones_inc;
            valid_d  = 1'b1;
            state_d  = ST_DONE;
`ifdef SC_BIPOLAR_EN
            bp_d     = $signed({ones_inc, 1'b0}) - $signed({1'b0, WINDOW_W});
`endif
          end
        end
      end
      ST_DONE: begin
        // A start without out_ready must not disturb the pending result.
        if (bus.out_ready) begin
          valid_d = 1'b0;
          if (bus.start) begin
            state_d = ST_RUN;
            ones_d  = '0;
            samp_d  = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial count at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ones_q   <= '0;
      samp_q   <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
`ifdef SC_BIPOLAR_EN
      bp_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ones_q   <= ones_d;
      samp_q   <= samp_d;
      result_q <= result_d;
      valid_q  <= valid_d;
`ifdef SC_BIPOLAR_EN
      bp_q     <= bp_d;
`endif
    end
  end

  assign bus.result    = result_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = (state_q == ST_RUN);
  assign state_dbg     = state_q;
`ifdef SC_BIPOLAR_EN
  assign bus.result_bp = bp_q;
`endif

endmodule

// File: tb/tb_sc_stream_counter.sv
// Bench for sc_stream_counter: randomized and directed windows, expected
// counts computed from the fed samples and queued; a negedge monitor pops and
// compares on every accepted result. A second instance covers WINDOW=1.
module tb_sc_stream_counter;

  localparam int WIDTH  = 8;
  localparam int WINDOW = 255;
  localparam logic [7:0] SC_INPUT_B = 8'd128;

  localparam int P_ONES   = 0;
  localparam int P_ZEROS  = 1;
  localparam int P_ALT    = 2;
  localparam int P_TOGGLE = 3;
  localparam int P_RAND   = 4;
  localparam int P_LFSR   = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sc_stream_counter_if #(.WIDTH(WIDTH)) bus ();
  sc_stream_counter_if #(.WIDTH(WIDTH)) bus1 ();
  logic [1:0] state_dbg;
  logic [1:0] state_dbg1;

  sc_stream_counter #(.WIDTH(WIDTH), .WINDOW(WINDOW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  sc_stream_counter #(.WIDTH(WIDTH), .WINDOW(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus1),
    .state_dbg (state_dbg1)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp1_q[$];
`ifdef SC_BIPOLAR_EN
  int exp_bp_q[$];
`endif
  logic [7:0] lfsr;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every result that is handed over.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL result_unexpected: got %0d with empty queue", bus.result);
        end else begin
          check("result", bus.result, exp_q.pop_front());
`ifdef SC_BIPOLAR_EN
          check("result_bp", bus.result_bp, exp_bp_q.pop_front());
`endif
        end
      end
      if (bus1.out_valid && bus1.out_ready) begin
        if (exp1_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL w1_result_unexpected: got %0d with empty queue", bus1.result);
        end else begin
          check("w1_result", bus1.result, exp1_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Feed one window; the model is just the count of ones among valid samples.
  task automatic run_window(input int pat, input bit do_start, output int cycles);
    int n;
    int ones;
    bit v;
    bit b;
    n = 0;
    ones = 0;
    cycles = 0;
    if (do_start) begin
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
    end
    while (n < WINDOW) begin
      v = 1'b1;
      b = 1'b0;
      case (pat)
        P_ONES:   b = 1'b1;
        P_ZEROS:  b = 1'b0;
        P_ALT:    b = (n % 2 == 0);
        P_TOGGLE: begin v = (cycles % 2 == 0); b = 1'b1; end
        P_RAND: begin
          v = ($urandom_range(0, 3) != 0);
          b = 1'($urandom_range(0, 1));
          bus.start = ($urandom_range(0, 7) == 0);
        end
        P_LFSR: begin
          b = (lfsr < SC_INPUT_B);
          lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
        default: v = 1'b0;
      endcase
      bus.bit_valid = v;
      bus.bit_in    = b;
      step();
      cycles++;
      if (v) begin
        n++;
        ones += int'(b);
      end
    end
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
    bus.start     = 1'b0;
    exp_q.push_back(ones[WIDTH-1:0]);
`ifdef SC_BIPOLAR_EN
    exp_bp_q.push_back(2 * ones - WINDOW);
`endif
    check("out_valid_on_last_sample", bus.out_valid, 1);
    check("busy_cleared_in_done", bus.busy, 0);
  endtask

  task automatic accept(input bit with_start);
    repeat ($urandom_range(0, 3)) step();
    bus.out_ready = 1'b1;
    bus.start     = with_start;
    step();
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    check("out_valid_after_accept", bus.out_valid, 0);
    check("busy_after_accept", bus.busy, longint'(with_start));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    bit b;
    bus.start = 0; bus.bit_in = 0; bus.bit_valid = 0; bus.out_ready = 0;
    bus1.start = 0; bus1.bit_in = 0; bus1.bit_valid = 0; bus1.out_ready = 0;
    lfsr = 8'h01;

    step();
    step();
    check("reset_result", bus.result, 0);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_busy", bus.busy, 0);
    rst = 1'b0;
    step();

    // All ones, alternating, valid toggling, all zeros with back-to-back start.
    run_window(P_ONES, 1'b1, cyc);
    check("all_ones_result_visible", bus.result, WINDOW);
    accept(1'b0);
    run_window(P_ALT, 1'b1, cyc);
    check("alt_result_visible", bus.result, 128);
    accept(1'b0);
    run_window(P_TOGGLE, 1'b1, cyc);
    // Valid on every other cycle starting with the first: last sample at 2*W-1.
    check("toggle_cycles", cyc, 2 * WINDOW - 1);
    check("toggle_result_visible", bus.result, WINDOW);
    accept(1'b0);
    run_window(P_ZEROS, 1'b1, cyc);
    accept(1'b1);
    run_window(P_RAND, 1'b0, cyc);
    accept(1'b0);

    // LFSR-driven SC stream, then hold in DONE with an ignored start pulse.
    lfsr = 8'h01;
    run_window(P_LFSR, 1'b1, cyc);
    for (int i = 0; i < 20; i++) begin
      bus.start = (i == 10);
      step();
      check("hold_out_valid", bus.out_valid, 1);
      check("hold_result", bus.result, exp_q[0]);
    end
    bus.start = 1'b0;
    accept(1'b1);
    run_window(P_RAND, 1'b0, cyc);
    accept(1'b0);

    for (int k = 0; k < 3; k++) begin
      run_window(P_RAND, 1'b1, cyc);
      accept(k[0]);
      if (k[0]) begin
        run_window(P_RAND, 1'b0, cyc);
        accept(1'b0);
      end
    end

    // Asynchronous reset mid-window discards the partial count.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.bit_valid = 1'b1;
    bus.bit_in = 1'b1;
    repeat (100) step();
    rst = 1'b1;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_result", bus.result, 0);
    bus.bit_valid = 1'b0;
    bus.bit_in = 1'b0;
    #1;
    rst = 1'b0;
    step();
    run_window(P_ONES, 1'b1, cyc);
    accept(1'b0);

    // WINDOW=1 instance: completes on the first valid sample.
    bus1.start = 1'b1;
    step();
    bus1.start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      check("w1_no_early_valid", bus1.out_valid, 0);
      b = 1'($urandom_range(0, 1));
      bus1.bit_valid = 1'b1;
      bus1.bit_in = b;
      exp1_q.push_back({{(WIDTH-1){1'b0}}, b});
      step();
      bus1.bit_valid = 1'b0;
      bus1.bit_in = 1'b0;
      check("w1_valid", bus1.out_valid, 1);
      bus1.out_ready = 1'b1;
      bus1.start = 1'b1;
      step();
      bus1.out_ready = 1'b0;
      bus1.start = 1'b0;
      check("w1_busy_b2b", bus1.busy, 1);
    end

    repeat (3) step();
    check("queue_drained", exp_q.size(), 0);
    check("w1_queue_drained", exp1_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
